// File: rtl/seven_seg_multi.sv
// rtl/seven_seg_multi.sv - multiplexed 7-segment display driver with hex/decimal write path
//
// Optional feature: define SEVEN_SEG_LZ_BLANK_EN to blank leading-zero digits.
//
// Ports:
//   clk     - clock, all logic on rising edge
//   rst     - asynchronous active-high reset
//   data    - 4*DIGITS-bit value to display (hex nibbles or binary for decimal)
//   dp      - per-digit decimal points, bit 0 = rightmost digit
//   base    - 0 = hex display, 1 = decimal display
//   wen     - write request, accepted when rdy=1
//   rdy     - high when a write will be accepted
//   done    - one-cycle pulse when new content reaches the display register
//   leds_o  - bit 7 = dp, bits 6..0 = segments g..a (polarity per SEG_ACT_LOW)
//   sels_o  - one-hot digit select, bit 0 = rightmost digit (polarity per SEL_ACT_LOW)
module seven_seg_multi #(
    parameter int DIGITS      = 6,
    parameter int SCAN_DIV    = 50000,
    parameter int SEG_ACT_LOW = 1,
    parameter int SEL_ACT_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  base,
    input  logic                  wen,
    output logic                  rdy,
    output logic                  done,
    output logic [7:0]            leds_o,
    output logic [DIGITS-1:0]     sels_o
);

    localparam int NB = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(NB);
    localparam logic [PW-1:0] PS_MAX    = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(NB - 1);
    localparam logic [7:0]    LEDS_OFF  = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SELS_OFF = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONV,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [NB-1:0]     bin;
    logic [NB-1:0]     bcd;
    logic [NB-1:0]     bcd_adj;
    logic              ovf;
    logic [DIGITS-1:0] cap_dp;
    logic              cap_base;
    logic [CW-1:0]     conv_cnt;

    logic [NB-1:0]     disp;
    logic [DIGITS-1:0] disp_dp;
    logic              disp_ovf;

    logic [PW-1:0]     ps_cnt;
    logic [IW-1:0]     idx, idx_n;
    logic              scan_on, on_n;
    logic [DIGITS-1:0] blank_v;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic [6:0]        cur_seg;

    function automatic logic [6:0] seg_of(input logic [3:0] v);
        case (v)
            4'h0: seg_of = 7'h3F;
            4'h1: seg_of = 7'h06;
            4'h2: seg_of = 7'h5B;
            4'h3: seg_of = 7'h4F;
            4'h4: seg_of = 7'h66;
            4'h5: seg_of = 7'h6D;
            4'h6: seg_of = 7'h7D;
            4'h7: seg_of = 7'h07;
            4'h8: seg_of = 7'h7F;
            4'h9: seg_of = 7'h6F;
            4'hA: seg_of = 7'h77;
            4'hB: seg_of = 7'h7C;
            4'hC: seg_of = 7'h39;
            4'hD: seg_of = 7'h5E;
            4'hE: seg_of = 7'h79;
            default: seg_of = 7'h71;
        endcase
    endfunction

    assign rdy = (state == S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (wen) state_n = base ? S_CONV : S_DONE;
            S_CONV: if (conv_cnt == STEP_LAST) state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
    end

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin      <= '0;
            bcd      <= '0;
            ovf      <= 1'b0;
            cap_dp   <= '0;
            cap_base <= 1'b0;
            conv_cnt <= '0;
            disp     <= '0;
            disp_dp  <= '0;
            disp_ovf <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (wen) begin
                        bin      <= data;
                        cap_dp   <= dp;
                        cap_base <= base;
                        bcd      <= '0;
                        ovf      <= 1'b0;
                        conv_cnt <= '0;
                    end
                end
                S_CONV: begin
                    // A bit leaving the top BCD digit means value >= 10^DIGITS.
                    bcd      <= {bcd_adj[NB-2:0], bin[NB-1]};
                    bin      <= {bin[NB-2:0], 1'b0};
                    ovf      <= ovf | bcd_adj[NB-1];
                    conv_cnt <= conv_cnt + 1'b1;
                end
                default: begin
                    disp     <= cap_base ? bcd : bin;
                    disp_ovf <= cap_base & ovf;
                    disp_dp  <= cap_dp;
                    done     <= 1'b1;
                end
            endcase
        end
    end

    // Scan: the first wrap after reset turns the outputs on at digit 0.
    always_comb begin
        idx_n = idx;
        on_n  = scan_on;
        if (ps_cnt == PS_MAX) begin
            on_n = 1'b1;
            if (!scan_on)            idx_n = '0;
            else if (idx == IDX_MAX) idx_n = '0;
            else                     idx_n = idx + 1'b1;
        end
    end

    always_comb begin
        blank_v = '0;
`ifdef SEVEN_SEG_LZ_BLANK_EN
        begin
            logic lz;
            lz = 1'b1;
            for (int i = DIGITS - 1; i >= 1; i--) begin
                lz         = lz & (disp[i*4 +: 4] == 4'd0);
                blank_v[i] = lz;
            end
        end
`endif
    end

    always_comb begin
        cur_nib   = 4'd0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IW'(i) == idx_n) begin
                cur_nib   = disp[i*4 +: 4];
                cur_dp    = disp_dp[i];
                cur_blank = blank_v[i];
            end
        end
        if (disp_ovf)       cur_seg = 7'h40;
        else if (cur_blank) cur_seg = 7'h00;
        else                cur_seg = seg_of(cur_nib);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_cnt  <= '0;
            idx     <= '0;
            scan_on <= 1'b0;
            leds_o  <= LEDS_OFF;
            sels_o  <= SELS_OFF;
        end else begin
            ps_cnt  <= (ps_cnt == PS_MAX) ? '0 : ps_cnt + 1'b1;
            idx     <= idx_n;
            scan_on <= on_n;
            if (on_n) begin
                leds_o <= (SEG_ACT_LOW != 0) ? ~{cur_dp, cur_seg} : {cur_dp, cur_seg};
                sels_o <= (SEL_ACT_LOW != 0) ? ~(DIGITS'(1) << idx_n) : (DIGITS'(1) << idx_n);
            end else begin
                leds_o <= LEDS_OFF;
                sels_o <= SELS_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_multi.sv
// tb/tb_seven_seg_multi.sv - directed self-checking bench for seven_seg_multi
module tb_seven_seg_multi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] data = '0;
    logic [5:0]  dp = '0;
    logic        base = 1'b0;
    logic        wen = 1'b0;
    logic        rdy;
    logic        done;
    logic [7:0]  leds_o;
    logic [5:0]  sels_o;

    int checks = 0;
    int errors = 0;
    int done_at, rdy_at, pulses;

`ifdef SEVEN_SEG_LZ_BLANK_EN
    localparam logic [7:0] LZ = 8'hFF;
`else
    localparam logic [7:0] LZ = 8'hC0;
`endif

    seven_seg_multi #(
        .DIGITS(6), .SCAN_DIV(4), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .dp(dp), .base(base), .wen(wen),
        .rdy(rdy), .done(done), .leds_o(leds_o), .sels_o(sels_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show_check(input string tag, input int k, input logic [7:0] exp);
        logic [5:0] want;
        bit found;
        want  = ~(6'd1 << k);
        found = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (sels_o === want) begin
                found = 1;
                break;
            end
        end
        check({tag, "_sel"}, 32'(found), 32'd1);
        check(tag, 32'(leds_o), 32'(exp));
    endtask

    task automatic write_start(input logic b, input logic [23:0] d, input logic [5:0] p);
        data = d;
        dp   = p;
        base = b;
        wen  = 1'b1;
        tick();
        wen  = 1'b0;
        check("rdy_low_after_accept", 32'(rdy), 32'd0);
    endtask

    task automatic measure(input bit repulse, output int d_at, output int r_at, output int np);
        d_at = 0;
        r_at = 0;
        np   = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                np++;
                if (d_at == 0) d_at = i;
            end
            if (rdy === 1'b1 && r_at == 0) r_at = i;
            if (repulse && i == 2) begin
                wen  = 1'b1;
                data = 24'h000999;
                base = 1'b0;
            end else if (repulse && i == 3) begin
                wen = 1'b0;
            end
        end
    endtask

    initial begin
        // reset state
        repeat (3) tick();
        check("rst_rdy", 32'(rdy), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_leds", 32'(leds_o), 32'hFF);
        check("rst_sels", 32'(sels_o), 32'h3F);

        // release and first prescaler wrap
        rst = 1'b0;
        tick();
        check("rel_sels_e1", 32'(sels_o), 32'h3F);
        tick();
        tick();
        check("rel_sels_e3", 32'(sels_o), 32'h3F);
        tick();
        check("rel_sels_wrap", 32'(sels_o), 32'h3E);
        check("rel_leds_d0", 32'(leds_o), 32'hC0);
        repeat (4) tick();
        check("rel_sels_d1", 32'(sels_o), 32'h3D);
        check("rel_leds_d1", 32'(leds_o), 32'(LZ));

        // hex write
        write_start(1'b0, 24'hABCDEF, 6'h01);
        tick();
        check("hex_done", 32'(done), 32'd1);
        check("hex_rdy", 32'(rdy), 32'd1);
        tick();
        check("hex_done_one_cycle", 32'(done), 32'd0);
        show_check("hex_d0", 0, 8'h0E);
        show_check("hex_d1", 1, 8'h86);
        show_check("hex_d5", 5, 8'h88);

        // decimal 257
        write_start(1'b1, 24'd257, 6'h00);
        measure(1'b0, done_at, rdy_at, pulses);
        check("dec_done_at", 32'(done_at), 32'd25);
        check("dec_rdy_at", 32'(rdy_at), 32'd25);
        check("dec_pulses", 32'(pulses), 32'd1);
        show_check("dec_d0", 0, 8'hF8);
        show_check("dec_d1", 1, 8'h92);
        show_check("dec_d2", 2, 8'hA4);
        show_check("dec_d3", 3, LZ);
        show_check("dec_d5", 5, LZ);

        // decimal overflow, dp still honoured on digit 5
        write_start(1'b1, 24'd1000000, 6'h20);
        measure(1'b0, done_at, rdy_at, pulses);
        check("ovf_pulses", 32'(pulses), 32'd1);
        show_check("ovf_d0", 0, 8'hBF);
        show_check("ovf_d3", 3, 8'hBF);
        show_check("ovf_d5", 5, 8'h3F);

        // second wen during conversion is ignored
        write_start(1'b1, 24'd123, 6'h00);
        measure(1'b1, done_at, rdy_at, pulses);
        check("busy_done_at", 32'(done_at), 32'd25);
        check("busy_pulses", 32'(pulses), 32'd1);
        show_check("busy_d0", 0, 8'hB0);
        show_check("busy_d1", 1, 8'hA4);
        show_check("busy_d2", 2, 8'hF9);

        // reset mid-conversion
        write_start(1'b1, 24'd999999, 6'h3F);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("abort_rdy", 32'(rdy), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sels", 32'(sels_o), 32'h3F);
        check("abort_leds", 32'(leds_o), 32'hFF);
        rst = 1'b0;
        measure(1'b0, done_at, rdy_at, pulses);
        check("abort_no_done", 32'(pulses), 32'd0);
        show_check("abort_d0", 0, 8'hC0);
        show_check("abort_d5", 5, LZ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
